// File: rtl/issue_sequencer.sv
// ---------------------------------------------------------------------------
// issue_sequencer
//   Issue-stage controller for the in-order superscalar core. Holds one
//   decoded bundle of up to WIDTH instructions and, each cycle, issues the
//   longest in-order prefix that the scoreboard allows. Leftover slots are
//   compacted down to slot 0 so the oldest instruction is always in lane 0.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  decode bundle handshake
//   in_mask            per-slot valid (contiguous prefix)
//   in_instr           per-slot payload
//   in_rs1/rs2/rd      per-slot register indices
//   in_rd_valid        per-slot writes-rd flag
//   in_branch          per-slot is-branch flag
//   sb_rs1/sb_rs2      sources of the unissued slots to the scoreboard
//   sb_can_issue       scoreboard verdict per lane
//   sb_rd/sb_rd_valid/sb_branch  fill-port data for lanes issuing now
//   issue_mask         lanes issuing this cycle (contiguous prefix)
//   issue_instr        payloads on issue lanes
//   flush              branch-mispredict flush
//   stall_cycles       saturating count of stalled cycles
// ---------------------------------------------------------------------------
module issue_sequencer #(
   parameter int WIDTH           = 4,
   parameter int RD_WIDTH        = 5,
   parameter int INSTR_WIDTH     = 32,
   parameter int STALL_CNT_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             in_mask,
   input  logic [WIDTH*INSTR_WIDTH-1:0] in_instr,
   input  logic [WIDTH*RD_WIDTH-1:0]    in_rs1,
   input  logic [WIDTH*RD_WIDTH-1:0]    in_rs2,
   input  logic [WIDTH*RD_WIDTH-1:0]    in_rd,
   input  logic [WIDTH-1:0]             in_rd_valid,
   input  logic [WIDTH-1:0]             in_branch,
   output logic [WIDTH*RD_WIDTH-1:0]    sb_rs1,
   output logic [WIDTH*RD_WIDTH-1:0]    sb_rs2,
   input  logic [WIDTH-1:0]             sb_can_issue,
   output logic [WIDTH*RD_WIDTH-1:0]    sb_rd,
   output logic [WIDTH-1:0]             sb_rd_valid,
   output logic [WIDTH-1:0]             sb_branch,
   output logic [WIDTH-1:0]             issue_mask,
   output logic [WIDTH*INSTR_WIDTH-1:0] issue_instr,
   input  logic                         flush,
   output logic [STALL_CNT_WIDTH-1:0]   stall_cycles
);

   // slot storage; slot 0 is always the oldest unissued instruction
   logic [WIDTH-1:0][INSTR_WIDTH-1:0] instr_q, instr_d;
   logic [WIDTH-1:0][RD_WIDTH-1:0]    rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic [WIDTH-1:0]                  vld_q, vld_d, rdv_q, rdv_d, br_q, br_d;
   logic [STALL_CNT_WIDTH-1:0]        stall_q, stall_d;

   int   n_c;      // number of slots issuing this cycle
   int   cnt_c;    // number of valid slots
   logic run_c;    // still extending the issue prefix

   // issue prefix: stops at the first blocked/empty slot and right after a branch
   always_comb begin
      n_c        = 0;
      cnt_c      = 0;
      run_c      = ~flush;
      issue_mask = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (run_c && vld_q[i] && sb_can_issue[i]) begin
            issue_mask[i] = 1'b1;
            n_c           = i + 1;
            if (br_q[i]) run_c = 1'b0;
         end else begin
            run_c = 1'b0;
         end
         if (vld_q[i]) cnt_c = cnt_c + 1;
      end
   end

   // bundle is done when everything left issues now; never accept during flush
   assign in_ready = (n_c == cnt_c) && !flush;

   always_comb begin
      sb_rs1 = '0;
      sb_rs2 = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (vld_q[i]) begin
            sb_rs1[i*RD_WIDTH +: RD_WIDTH] = rs1_q[i];
            sb_rs2[i*RD_WIDTH +: RD_WIDTH] = rs2_q[i];
         end
      end
   end

   assign issue_instr  = instr_q;
   assign sb_rd        = rd_q;
   assign sb_rd_valid  = issue_mask & rdv_q;
   assign sb_branch    = issue_mask & br_q;
   assign stall_cycles = stall_q;

   // next state: compact by n_c, then flush clears, then a new bundle overrides
   always_comb begin
      instr_d = '0;
      rs1_d   = '0;
      rs2_d   = '0;
      rd_d    = '0;
      rdv_d   = '0;
      br_d    = '0;
      vld_d   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         for (int j = i; j < WIDTH; j++) begin
            if (j - i == n_c) begin
               instr_d[i] = instr_q[j];
               rs1_d[i]   = rs1_q[j];
               rs2_d[i]   = rs2_q[j];
               rd_d[i]    = rd_q[j];
               rdv_d[i]   = rdv_q[j];
               br_d[i]    = br_q[j];
               vld_d[i]   = vld_q[j];
            end
         end
      end
      if (flush) vld_d = '0;
      if (in_valid && in_ready) begin
         instr_d = in_instr;
         rs1_d   = in_rs1;
         rs2_d   = in_rs2;
         rd_d    = in_rd;
         rdv_d   = in_rd_valid;
         br_d    = in_branch;
         vld_d   = in_mask;
      end

      stall_d = stall_q;
      if ((|vld_q) && (n_c == 0) && !flush && (stall_q != '1))
         stall_d = stall_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         rdv_q   <= '0;
         br_q    <= '0;
         vld_q   <= '0;
         stall_q <= '0;
      end else begin
         instr_q <= instr_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         rd_q    <= rd_d;
         rdv_q   <= rdv_d;
         br_q    <= br_d;
         vld_q   <= vld_d;
         stall_q <= stall_d;
      end
   end

endmodule
